// File: rtl/axi_sram_slave.sv
// AXI3 slave bridging independent read and write burst engines onto one single-port SRAM.
// Reads take priority over writes for the SRAM port; all bursts are INCR with 4-byte beats.
module axi_sram_slave #(
    parameter int MEM_AW = 12
) (
    input  logic              aclk,
    input  logic              areset,
    // AR channel
    input  logic [3:0]        arid,
    input  logic [31:0]       araddr,
    input  logic [7:0]        arlen,
    input  logic [2:0]        arsize,
    input  logic [1:0]        arburst,
    input  logic [1:0]        arlock,
    input  logic [3:0]        arcache,
    input  logic [2:0]        arprot,
    input  logic              arvalid,
    output logic              arready,
    // R channel
    output logic [3:0]        rid,
    output logic [31:0]       rdata,
    output logic [1:0]        rresp,
    output logic              rlast,
    output logic              rvalid,
    input  logic              rready,
    // AW channel
    input  logic [3:0]        awid,
    input  logic [31:0]       awaddr,
    input  logic [7:0]        awlen,
    input  logic [2:0]        awsize,
    input  logic [1:0]        awburst,
    input  logic [1:0]        awlock,
    input  logic [3:0]        awcache,
    input  logic [2:0]        awprot,
    input  logic              awvalid,
    output logic              awready,
    // W channel
    input  logic [3:0]        wid,
    input  logic [31:0]       wdata,
    input  logic [3:0]        wstrb,
    input  logic              wlast,
    input  logic              wvalid,
    output logic              wready,
    // B channel
    output logic [3:0]        bid,
    output logic [1:0]        bresp,
    output logic              bvalid,
    input  logic              bready,
    // SRAM port
    output logic              ram_en,
    output logic [3:0]        ram_we,
    output logic [MEM_AW-1:0] ram_addr,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {R_IDLE, R_READ, R_DATA} r_state_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    r_state_t          r_state;
    logic [MEM_AW-1:0] r_addr;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [3:0]        r_id;
    logic [31:0]       rdata_q;
    logic              r_held;

    w_state_t          w_state;
    logic [MEM_AW-1:0] w_addr;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [3:0]        w_id;
    logic              w_err;
    logic [1:0]        bresp_q;

    logic              w_hs;
    logic              w_last_beat;
    logic              wlast_bad;

    logic unused_inputs;
    assign unused_inputs = ^{arsize, arburst, arlock, arcache, arprot, araddr[31:MEM_AW+2], araddr[1:0],
                             awsize, awburst, awlock, awcache, awprot, awaddr[31:MEM_AW+2], awaddr[1:0], wid};

    // Handshake outputs are state decodes, forced to their reset values while areset is high.
    assign arready = areset || (r_state == R_IDLE);
    assign rvalid  = !areset && (r_state == R_DATA);
    assign rlast   = rvalid && (r_cnt == r_len);
    assign rid     = r_id;
    assign rresp   = 2'b00;
    assign awready = areset || (w_state == W_IDLE);
    assign wready  = !areset && (w_state == W_DATA) && (r_state != R_READ);
    assign bvalid  = !areset && (w_state == W_RESP);
    assign bid     = w_id;
    assign bresp   = areset ? 2'b00 : bresp_q;

    // SRAM data arrives in the first R_DATA cycle; it is passed straight through, then held.
    assign rdata = (r_state == R_DATA && !r_held) ? ram_rdata : rdata_q;

    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_cnt == w_len);
    assign wlast_bad   = (wlast != w_last_beat);

    // NOTE: always_comb assigns every output first so no path can infer a latch.
    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = '0;
        ram_wdata = '0;
        if (!areset) begin
            if (r_state == R_READ) begin
                ram_en   = 1'b1;
                ram_addr = r_addr;
            end else if (w_hs) begin
                ram_en    = 1'b1;
                ram_we    = wstrb;
                ram_addr  = w_addr;
                ram_wdata = wdata;
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= R_IDLE;
            r_addr  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_id    <= '0;
            rdata_q <= '0;
            r_held  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: if (arvalid) begin
                    r_id    <= arid;
                    r_addr  <= araddr[MEM_AW+1:2];
                    r_len   <= arlen;
                    r_cnt   <= '0;
                    r_state <= R_READ;
                end
                R_READ: begin
                    r_held  <= 1'b0;
                    r_state <= R_DATA;
                end
                R_DATA: begin
                    if (!r_held) begin
                        rdata_q <= ram_rdata;
                        r_held  <= 1'b1;
                    end
                    if (rready) begin
                        if (r_cnt == r_len) begin
                            r_state <= R_IDLE;
                        end else begin
                            r_addr  <= r_addr + 1'b1;
                            r_cnt   <= r_cnt + 8'd1;
                            r_state <= R_READ;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state <= W_IDLE;
            w_addr  <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_id    <= '0;
            w_err   <= 1'b0;
            bresp_q <= 2'b00;
        end else begin
            case (w_state)
                W_IDLE: if (awvalid) begin
                    w_id    <= awid;
                    w_addr  <= awaddr[MEM_AW+1:2];
                    w_len   <= awlen;
                    w_cnt   <= '0;
                    w_err   <= 1'b0;
                    w_state <= W_DATA;
                end
                W_DATA: if (w_hs) begin
                    // The burst ends on the beat count; wlast only feeds the error flag.
                    if (w_last_beat) begin
                        bresp_q <= (w_err || wlast_bad) ? 2'b10 : 2'b00;
                        w_state <= W_RESP;
                    end else begin
                        w_err  <= w_err || wlast_bad;
                        w_addr <= w_addr + 1'b1;
                        w_cnt  <= w_cnt + 8'd1;
                    end
                end
                W_RESP: if (bready) w_state <= W_IDLE;
                default: w_state <= W_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: SRAM model, table of single-beat write/read vectors,
// and hand-written sequences for latency, bursts, port conflict, back-pressure, wlast error and reset.
module tb_axi_sram_slave;

    localparam int MEM_AW = 12;

    logic        aclk = 1'b0;
    logic        areset;
    logic [3:0]  arid, awid, wid, rid, bid;
    logic [31:0] araddr, awaddr, wdata, rdata;
    logic [7:0]  arlen, awlen;
    logic [2:0]  arsize, arprot, awsize, awprot;
    logic [1:0]  arburst, arlock, awburst, awlock, rresp, bresp;
    logic [3:0]  arcache, awcache, wstrb, ram_we;
    logic        arvalid, arready, rlast, rvalid, rready;
    logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic        ram_en;
    logic [MEM_AW-1:0] ram_addr;
    logic [31:0] ram_wdata, ram_rdata;

    always #5 aclk = ~aclk;

    axi_sram_slave #(.MEM_AW(MEM_AW)) dut (
        .aclk(aclk), .areset(areset),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
        .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata)
    );

    // Single-port SRAM model with byte enables; the preload port lets the bench seed words.
    logic [31:0] mem [0:(1<<MEM_AW)-1];
    logic        pl_en;
    logic [11:0] pl_addr;
    logic [31:0] pl_data;

    always @(posedge aclk) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (ram_en) begin
            if (ram_we == 4'h0) ram_rdata <= mem[ram_addr];
            else for (int b = 0; b < 4; b++)
                if (ram_we[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
    end

    int total  = 0;
    int passed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(posedge aclk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] d);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        step();
        pl_en = 1'b0;
    endtask

    logic [31:0] rd_buf [0:15];
    logic [3:0]  rd_id;
    logic [31:0] wr_buf [0:15];
    logic [1:0]  wr_bresp;
    logic [3:0]  wr_bid;

    task automatic ar_req(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        int k;
        arid = id; araddr = addr; arlen = len; arvalid = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!arready && k < 50) begin @(negedge aclk); k++; end
        if (!arready) check("ar_timeout", 32'd0, 32'd1);
        step();
        arvalid = 1'b0;
    endtask

    task automatic read_beats(input int n, input logic [7:0] len);
        for (int i = 0; i < n; i++) begin
            int k;
            k = 0;
            @(negedge aclk);
            while (!rvalid && k < 50) begin @(negedge aclk); k++; end
            if (!rvalid) begin
                check("r_timeout", 32'd0, 32'd1);
                return;
            end
            rd_buf[i] = rdata;
            rd_id     = rid;
            check("rlast", 32'(rlast), 32'(i == int'(len)));
            step();
        end
    endtask

    task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        ar_req(id, addr, len);
        read_beats(int'(len) + 1, len);
    endtask

    task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                            input logic [3:0] strb, input int wlast_idx);
        int k;
        awid = id; awaddr = addr; awlen = len; awvalid = 1'b1;
        k = 0;
        @(negedge aclk);
        while (!awready && k < 50) begin @(negedge aclk); k++; end
        if (!awready) check("aw_timeout", 32'd0, 32'd1);
        step();
        awvalid = 1'b0;
        for (int i = 0; i <= int'(len); i++) begin
            wvalid = 1'b1; wdata = wr_buf[i]; wstrb = strb; wlast = (i == wlast_idx);
            k = 0;
            @(negedge aclk);
            while (!wready && k < 50) begin @(negedge aclk); k++; end
            if (!wready) check("w_timeout", 32'd0, 32'd1);
            step();
        end
        wvalid = 1'b0; wlast = 1'b0;
        k = 0;
        @(negedge aclk);
        while (!bvalid && k < 50) begin @(negedge aclk); k++; end
        if (!bvalid) check("b_timeout", 32'd0, 32'd1);
        wr_bresp = bresp;
        wr_bid   = bid;
        step();
    endtask

    typedef struct {
        logic [31:0] waddr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs [5];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic ok;
        logic [31:0] first_data;

        vecs[0] = '{32'h0000_0200, 32'hA5A5_1234, 4'hF, 32'h0000_0200, 32'hA5A5_1234};
        vecs[1] = '{32'h0000_0204, 32'h1122_3344, 4'h1, 32'h0000_0204, 32'h0000_0044};
        vecs[2] = '{32'h0000_0208, 32'hCAFE_F00D, 4'hC, 32'h0000_0208, 32'hCAFE_0000};
        vecs[3] = '{32'h0004_020C, 32'h0BAD_CAFE, 4'hF, 32'h0000_020C, 32'h0BAD_CAFE};
        vecs[4] = '{32'h0000_3FFC, 32'h7654_3210, 4'h6, 32'hFFFF_FFFC, 32'h0054_3200};

        areset = 1'b1;
        arid = 0; araddr = 0; arlen = 0; arsize = 3'd2; arburst = 2'b01; arlock = 0; arcache = 0;
        arprot = 0; arvalid = 0; rready = 1'b1;
        awid = 0; awaddr = 0; awlen = 0; awsize = 3'd2; awburst = 2'b01; awlock = 0; awcache = 0;
        awprot = 0; awvalid = 0;
        wid = 0; wdata = 0; wstrb = 0; wlast = 0; wvalid = 0; bready = 1'b1;
        pl_en = 0; pl_addr = 0; pl_data = 0;

        // Reset values: {arready, awready, rvalid, wready, bvalid, rlast, ram_en, ram_we, rresp, bresp}
        @(negedge aclk);
        check("reset_during", 32'({arready, awready, rvalid, wready, bvalid, rlast, ram_en, ram_we, rresp, bresp}),
              32'({2'b11, 13'b0}));
        step();
        step();
        areset = 1'b0;
        @(negedge aclk);
        check("reset_after", 32'({arready, awready, rvalid, wready, bvalid, rlast, ram_en, ram_we, rresp, bresp}),
              32'({2'b11, 13'b0}));
        step();

        // Single read: rvalid appears exactly two cycles after the AR handshake.
        preload(12'h004, 32'hDEAD_BEEF);
        ar_req(4'd3, 32'h0000_0010, 8'd0);
        @(negedge aclk);
        check("rd_t1_rvalid", 32'(rvalid), 32'd0);
        check("rd_t1_ram_en", 32'({ram_en, ram_we}), 32'h10);
        step();
        @(negedge aclk);
        check("rd_t2_rvalid", 32'(rvalid), 32'd1);
        check("rd_t2_rdata", rdata, 32'hDEAD_BEEF);
        check("rd_t2_rid", 32'(rid), 32'd3);
        check("rd_t2_rlast", 32'(rlast), 32'd1);
        check("rd_t2_rresp", 32'(rresp), 32'd0);
        step();

        // Table of single-beat write/read-back vectors (strobes, aliasing, top word).
        for (int i = 0; i < 5; i++) begin
            preload(vecs[i].waddr[13:2], 32'h0);
            wr_buf[0] = vecs[i].wdata;
            do_write(4'(i), vecs[i].waddr, 8'd0, vecs[i].wstrb, 0);
            check($sformatf("vec%0d_bresp", i), 32'(wr_bresp), 32'd0);
            check($sformatf("vec%0d_bid", i), 32'(wr_bid), 32'(i));
            do_read(4'(i + 8), vecs[i].raddr, 8'd0);
            check($sformatf("vec%0d_rdata", i), rd_buf[0], vecs[i].exp);
            check($sformatf("vec%0d_rid", i), 32'(rd_id), 32'(i + 8));
        end

        // Four-beat write burst to words 0x40..0x43.
        wr_buf[0] = 32'h0000_1111; wr_buf[1] = 32'h0000_2222;
        wr_buf[2] = 32'h0000_3333; wr_buf[3] = 32'h0000_4444;
        do_write(4'd1, 32'h0000_0100, 8'd3, 4'hF, 3);
        check("burst_bresp", 32'(wr_bresp), 32'd0);
        check("burst_bid", 32'(wr_bid), 32'd1);
        check("burst_w0", mem[12'h040], 32'h0000_1111);
        check("burst_w1", mem[12'h041], 32'h0000_2222);
        check("burst_w2", mem[12'h042], 32'h0000_3333);
        check("burst_w3", mem[12'h043], 32'h0000_4444);
        do_read(4'd2, 32'h0000_0104, 8'd2);
        check("burst_rd0", rd_buf[0], 32'h0000_2222);
        check("burst_rd2", rd_buf[2], 32'h0000_4444);

        // Address increment wraps from the top word back to word 0.
        wr_buf[0] = 32'hFEED_0FFF; wr_buf[1] = 32'hFEED_0000;
        do_write(4'd7, 32'h0000_3FFC, 8'd1, 4'hF, 1);
        do_read(4'd7, 32'h0000_3FFC, 8'd1);
        check("wrap_rd0", rd_buf[0], 32'hFEED_0FFF);
        check("wrap_rd1", rd_buf[1], 32'hFEED_0000);

        // Port conflict: R_READ steals the port for one cycle, the write beat follows.
        preload(12'h050, 32'h5555_AAAA);
        arid = 4'd5; araddr = 32'h0000_0140; arlen = 8'd0; arvalid = 1'b1;
        awid = 4'd6; awaddr = 32'h0000_0180; awlen = 8'd0; awvalid = 1'b1;
        @(negedge aclk);
        check("conf_ready", 32'({arready, awready}), 32'h3);
        step();
        arvalid = 1'b0; awvalid = 1'b0;
        wvalid = 1'b1; wdata = 32'h1234_5678; wstrb = 4'hF; wlast = 1'b1;
        @(negedge aclk);
        check("conf_wready_blocked", 32'(wready), 32'd0);
        check("conf_ram_read", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 4'h0, 12'h050}));
        step();
        @(negedge aclk);
        check("conf_wready_next", 32'(wready), 32'd1);
        check("conf_ram_write", 32'({ram_en, ram_we, ram_addr}), 32'({1'b1, 4'hF, 12'h060}));
        check("conf_rdata", rdata, 32'h5555_AAAA);
        check("conf_rvalid", 32'(rvalid), 32'd1);
        step();
        wvalid = 1'b0; wlast = 1'b0;
        @(negedge aclk);
        check("conf_bvalid", 32'({bvalid, bresp}), 32'({1'b1, 2'b00}));
        step();
        check("conf_mem", mem[12'h060], 32'h1234_5678);

        // Back-pressure: R outputs frozen and no SRAM activity while rready is low.
        preload(12'h070, 32'hAAAA_0001);
        preload(12'h071, 32'hAAAA_0002);
        rready = 1'b0;
        ar_req(4'd9, 32'h0000_01C0, 8'd1);
        step();
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge aclk);
            if (i == 0) first_data = rdata;
            if (!rvalid || rdata !== 32'hAAAA_0001 || rid !== 4'd9 || rlast !== 1'b0 || ram_en !== 1'b0)
                ok = 1'b0;
            step();
        end
        check("bp_stable", 32'(ok), 32'd1);
        check("bp_first_data", first_data, 32'hAAAA_0001);
        rready = 1'b1;
        read_beats(2, 8'd1);
        check("bp_rd0", rd_buf[0], 32'hAAAA_0001);
        check("bp_rd1", rd_buf[1], 32'hAAAA_0002);

        // wlast on the first of two beats: both beats still land, response is SLVERR.
        preload(12'h0C1, 32'h0);
        wr_buf[0] = 32'h0BEE_0000; wr_buf[1] = 32'h0BEE_0001;
        do_write(4'd2, 32'h0000_0300, 8'd1, 4'hF, 0);
        check("wlast_bresp", 32'(wr_bresp), 32'd2);
        check("wlast_w0", mem[12'h0C0], 32'h0BEE_0000);
        check("wlast_w1", mem[12'h0C1], 32'h0BEE_0001);
        wr_buf[0] = 32'h0BEE_0002;
        do_write(4'd3, 32'h0000_0308, 8'd0, 4'hF, 0);
        check("wlast_err_cleared", 32'(wr_bresp), 32'd0);

        // Reset in the middle of a four-beat read, then a fresh read.
        preload(12'h090, 32'hB000_0090);
        preload(12'h091, 32'hB000_0091);
        preload(12'h092, 32'hB000_0092);
        preload(12'h093, 32'hB000_0093);
        ar_req(4'hA, 32'h0000_0240, 8'd3);
        read_beats(2, 8'd3);
        check("rst_rd1", rd_buf[1], 32'hB000_0091);
        step();
        areset = 1'b1;
        @(negedge aclk);
        check("rst_during_rvalid", 32'(rvalid), 32'd0);
        step();
        areset = 1'b0;
        @(negedge aclk);
        check("rst_after", 32'({rvalid, arready, ram_en}), 32'b010);
        step();
        do_read(4'hB, 32'h0000_0248, 8'd0);
        check("rst_new_rdata", rd_buf[0], 32'hB000_0092);
        check("rst_new_rid", 32'(rd_id), 32'hB);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
